// File: rtl/mux_pkg.sv
// Shared constants and helpers for the N-to-1 stream multiplexer.
// The MODE values select the channel-selection policy of mux_stream_nto1.
package mux_pkg;

    localparam int MODE_SEL  = 0;
    localparam int MODE_PRIO = 1;
    localparam int MODE_RR   = 2;

    // The wrap is explicit so the pointer stays in range when n is not a power of two.
    function automatic int next_ptr(input int g, input int n);
        return (g == n - 1) ? 0 : g + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: a one-hot grant that starts searching at ptr.
// The pointer moves one past the winner, and only when adv reports a completed handshake.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         adv,
    output logic [N-1:0] grant
);

    localparam int SW = $clog2(N);

    logic [SW-1:0] ptr;
    logic [SW-1:0] gidx;
    logic          found;

    // First pass covers ptr..N-1 and second pass 0..ptr-1, giving the circular search order.
    always_comb begin
        grant = '0;
        gidx  = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!found && req[i] && (SW'(i) >= ptr)) begin
                found    = 1'b1;
                grant[i] = 1'b1;
                gidx     = SW'(i);
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!found && req[i] && (SW'(i) < ptr)) begin
                found    = 1'b1;
                grant[i] = 1'b1;
                gidx     = SW'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (adv) begin
            ptr <= SW'(next_ptr(int'(gidx), N));
        end
    end

endmodule

// File: rtl/mux_stream_nto1.sv
// N-to-1 registered stream multiplexer with valid/ready on every port.
// Selection policy is external select, fixed priority or round-robin, chosen by MODE.
module mux_stream_nto1
    import mux_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int N     = 4,
    parameter int MODE  = 2,
    parameter int SW    = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]     in_valid,
    output logic [N-1:0]     in_ready,
    input  logic [SW-1:0]    sel,
    output logic [WIDTH-1:0] out_data,
    output logic [SW-1:0]    out_chan,
    output logic             out_valid,
    input  logic             out_ready
);

    logic             load;
    logic             take;
    logic [N-1:0]     grant;
    logic [N-1:0]     grant_fix;
    logic [N-1:0]     grant_rr;
    logic [SW-1:0]    gidx;
    logic [WIDTH-1:0] gdata;
    logic             found;

    assign load = !out_valid || out_ready;

    // A select value with no matching channel (sel >= N) simply yields no grant.
    always_comb begin
        grant_fix = '0;
        found     = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (MODE == MODE_SEL) begin
                if ((sel == SW'(i)) && in_valid[i]) begin
                    grant_fix[i] = 1'b1;
                end
            end else if (!found && in_valid[i]) begin
                found        = 1'b1;
                grant_fix[i] = 1'b1;
            end
        end
    end

    generate
        if (MODE == MODE_RR) begin : g_rr
            rr_arbiter #(
                .N(N)
            ) u_arb (
                .clk   (clk),
                .rst   (rst),
                .req   (in_valid),
                .adv   (take),
                .grant (grant_rr)
            );
        end else begin : g_fix
            assign grant_rr = '0;
        end
    endgenerate

    assign grant    = (MODE == MODE_RR) ? grant_rr : grant_fix;
    assign in_ready = grant & {N{load && !rst}};
    assign take     = |in_ready;

    always_comb begin
        gidx  = '0;
        gdata = '0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                gidx  = SW'(i);
                gdata = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Output register: loads on a handshake, empties when free with nothing granted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
        end else if (load) begin
            if (take) begin
                out_valid <= 1'b1;
                out_data  <= gdata;
                out_chan  <= gidx;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mux_stream_nto1.sv
// Directed bench for mux_stream_nto1: one instance per selection policy, plus a 3-channel round-robin.
// Each task drives its own instance and compares against hand-computed values.
module tb_mux_stream_nto1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] d0, d1, d2;
    logic [3:0]  v0, v1, v2, r0, r1, r2;
    logic [1:0]  s0, s1, s2, oc0, oc1, oc2;
    logic [7:0]  od0, od1, od2;
    logic        ov0, ov1, ov2, or0, or1, or2;

    logic [23:0] d3;
    logic [2:0]  v3, r3;
    logic [1:0]  s3, oc3;
    logic [7:0]  od3;
    logic        ov3, or3;

    mux_stream_nto1 #(.WIDTH(8), .N(4), .MODE(0)) u_sel (
        .clk(clk), .rst(rst), .in_data(d0), .in_valid(v0), .in_ready(r0), .sel(s0),
        .out_data(od0), .out_chan(oc0), .out_valid(ov0), .out_ready(or0));

    mux_stream_nto1 #(.WIDTH(8), .N(4), .MODE(1)) u_prio (
        .clk(clk), .rst(rst), .in_data(d1), .in_valid(v1), .in_ready(r1), .sel(s1),
        .out_data(od1), .out_chan(oc1), .out_valid(ov1), .out_ready(or1));

    mux_stream_nto1 #(.WIDTH(8), .N(4), .MODE(2)) u_rr4 (
        .clk(clk), .rst(rst), .in_data(d2), .in_valid(v2), .in_ready(r2), .sel(s2),
        .out_data(od2), .out_chan(oc2), .out_valid(ov2), .out_ready(or2));

    mux_stream_nto1 #(.WIDTH(8), .N(3), .MODE(2)) u_rr3 (
        .clk(clk), .rst(rst), .in_data(d3), .in_valid(v3), .in_ready(r3), .sel(s3),
        .out_data(od3), .out_chan(oc3), .out_valid(ov3), .out_ready(or3));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        d1 = {8'h44, 8'h33, 8'h22, 8'h11};
        v1 = 4'hF;
        or1 = 1'b1;
        step();
        step();
        checks++; if (ov1 !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", ov1); end
        checks++; if (od1 !== 8'h00) begin errors++; $display("FAIL reset_out_data got %h exp 00", od1); end
        checks++; if (oc1 !== 2'd0) begin errors++; $display("FAIL reset_out_chan got %0d exp 0", oc1); end
        checks++; if (r1 !== 4'b0000) begin errors++; $display("FAIL reset_in_ready got %b exp 0000", r1); end
        rst = 1'b0;
        #1;
        checks++; if (r1 !== 4'b0001) begin errors++; $display("FAIL release_in_ready got %b exp 0001", r1); end
        step();
        checks++; if (ov1 !== 1'b1) begin errors++; $display("FAIL first_word_valid got %b exp 1", ov1); end
        checks++; if (od1 !== 8'h11) begin errors++; $display("FAIL first_word_data got %h exp 11", od1); end
        v1 = 4'h0;
        step();
        checks++; if (ov1 !== 1'b0) begin errors++; $display("FAIL drain_empty got %b exp 0", ov1); end
    endtask

    task automatic test_sel();
        d0 = {8'h44, 8'h33, 8'h22, 8'h11};
        v0 = 4'hF;
        s0 = 2'd2;
        or0 = 1'b1;
        #1;
        checks++; if (r0 !== 4'b0100) begin errors++; $display("FAIL sel2_in_ready got %b exp 0100", r0); end
        step();
        checks++; if (od0 !== 8'h33) begin errors++; $display("FAIL sel2_data got %h exp 33", od0); end
        checks++; if (oc0 !== 2'd2) begin errors++; $display("FAIL sel2_chan got %0d exp 2", oc0); end
        checks++; if (ov0 !== 1'b1) begin errors++; $display("FAIL sel2_valid got %b exp 1", ov0); end
        v0 = 4'b1011;
        #1;
        checks++; if (r0 !== 4'b0000) begin errors++; $display("FAIL sel_invalid_ready got %b exp 0000", r0); end
        step();
        checks++; if (ov0 !== 1'b0) begin errors++; $display("FAIL sel_invalid_valid got %b exp 0", ov0); end
        checks++; if (od0 !== 8'h33) begin errors++; $display("FAIL sel_hold_data got %h exp 33", od0); end
        s0 = 2'd3;
        #1;
        checks++; if (r0 !== 4'b1000) begin errors++; $display("FAIL sel3_in_ready got %b exp 1000", r0); end
        step();
        checks++; if (od0 !== 8'h44 || oc0 !== 2'd3) begin errors++; $display("FAIL sel3_word got %h/%0d exp 44/3", od0, oc0); end
        v0 = 4'h0;
        step();
    endtask

    task automatic test_prio();
        v1 = 4'b1010;
        #1;
        checks++; if (r1 !== 4'b0010) begin errors++; $display("FAIL prio_ready_a got %b exp 0010", r1); end
        step();
        checks++; if (oc1 !== 2'd1 || od1 !== 8'h22) begin errors++; $display("FAIL prio_word_a got %0d/%h exp 1/22", oc1, od1); end
        v1 = 4'b1000;
        #1;
        checks++; if (r1 !== 4'b1000) begin errors++; $display("FAIL prio_ready_b got %b exp 1000", r1); end
        step();
        checks++; if (oc1 !== 2'd3 || od1 !== 8'h44) begin errors++; $display("FAIL prio_word_b got %0d/%h exp 3/44", oc1, od1); end
        v1 = 4'h0;
        step();
    endtask

    task automatic test_rr();
        int c;
        d2 = {8'h44, 8'h33, 8'h22, 8'h11};
        v2 = 4'hF;
        or2 = 1'b1;
        for (int k = 0; k < 8; k++) begin
            c = k % 4;
            #1;
            checks++; if (r2 !== (4'b0001 << c)) begin errors++; $display("FAIL rr4_ready_%0d got %b exp %b", k, r2, 4'b0001 << c); end
            step();
            checks++; if (oc2 !== 2'(c) || od2 !== d2[c*8 +: 8]) begin errors++; $display("FAIL rr4_word_%0d got %0d/%h exp %0d/%h", k, oc2, od2, c, d2[c*8 +: 8]); end
        end
        v2 = 4'h0;
        step();
        d3 = {8'h33, 8'h22, 8'h11};
        v3 = 3'b111;
        or3 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            c = k % 3;
            #1;
            checks++; if (r3 !== (3'b001 << c)) begin errors++; $display("FAIL rr3_ready_%0d got %b exp %b", k, r3, 3'b001 << c); end
            step();
            checks++; if (oc3 !== 2'(c) || od3 !== d3[c*8 +: 8]) begin errors++; $display("FAIL rr3_word_%0d got %0d/%h exp %0d/%h", k, oc3, od3, c, d3[c*8 +: 8]); end
        end
        v3 = 3'b000;
        step();
    endtask

    task automatic test_backpressure();
        int seq[4];
        int rcv[4];
        int exp_order[9];
        int fires;
        int ec;
        logic [3:0] hs;
        logic [7:0] ew;
        exp_order = '{0, 1, 2, 3, 0, 1, 2, 3, 0};
        fires = 0;
        for (int i = 0; i < 4; i++) begin
            seq[i] = 0;
            rcv[i] = 0;
        end
        for (int c = 0; c < 16; c++) begin
            for (int i = 0; i < 4; i++) d2[i*8 +: 8] = {4'(i + 1), 4'(seq[i])};
            v2 = (c <= 13) ? 4'hF : 4'h0;
            or2 = (c >= 1 && c <= 5) ? 1'b0 : 1'b1;
            #1;
            if (c >= 1 && c <= 5) begin
                checks++; if (r2 !== 4'b0000) begin errors++; $display("FAIL stall_ready_c%0d got %b exp 0000", c, r2); end
                checks++; if (od2 !== 8'h10 || ov2 !== 1'b1) begin errors++; $display("FAIL stall_hold_c%0d got %h/%b exp 10/1", c, od2, ov2); end
            end
            hs = v2 & r2;
            if (ov2 && or2) begin
                checks++;
                if (fires >= 9) begin
                    errors++; $display("FAIL bp_extra_word got chan %0d exp none", oc2);
                end else begin
                    ec = exp_order[fires];
                    ew = {4'(ec + 1), 4'(rcv[ec])};
                    if (oc2 !== 2'(ec) || od2 !== ew) begin
                        errors++; $display("FAIL bp_word_%0d got %0d/%h exp %0d/%h", fires, oc2, od2, ec, ew);
                    end
                    rcv[ec]++;
                end
                fires++;
            end
            step();
            for (int i = 0; i < 4; i++) if (hs[i]) seq[i]++;
        end
        checks++; if (fires != 9) begin errors++; $display("FAIL bp_word_count got %0d exp 9", fires); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (rcv[i] != seq[i]) begin errors++; $display("FAIL bp_chan%0d_count got %0d exp %0d", i, rcv[i], seq[i]); end
        end
    endtask

    task automatic test_async_reset();
        d2 = {8'h44, 8'h33, 8'h22, 8'h11};
        v2 = 4'hF;
        or2 = 1'b0;
        step();
        checks++; if (ov2 !== 1'b1 || oc2 !== 2'd1) begin errors++; $display("FAIL pre_reset_word got %b/%0d exp 1/1", ov2, oc2); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (ov2 !== 1'b0) begin errors++; $display("FAIL async_clear_valid got %b exp 0", ov2); end
        checks++; if (r2 !== 4'b0000 || od2 !== 8'h00) begin errors++; $display("FAIL async_clear_state got %b/%h exp 0000/00", r2, od2); end
        step();
        rst = 1'b0;
        or2 = 1'b1;
        #1;
        checks++; if (r2 !== 4'b0001) begin errors++; $display("FAIL rr_restart_ready got %b exp 0001", r2); end
        step();
        checks++; if (ov2 !== 1'b1 || oc2 !== 2'd0 || od2 !== 8'h11) begin errors++; $display("FAIL rr_restart_word got %b/%0d/%h exp 1/0/11", ov2, oc2, od2); end
        v2 = 4'h0;
        step();
    endtask

    initial begin
        d0 = '0; d1 = '0; d2 = '0; d3 = '0;
        v0 = '0; v1 = '0; v2 = '0; v3 = '0;
        s0 = '0; s1 = '0; s2 = '0; s3 = '0;
        or0 = 1'b1; or1 = 1'b1; or2 = 1'b1; or3 = 1'b1;
        test_reset();
        test_sel();
        test_prio();
        test_rr();
        test_backpressure();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_stream_nto1.md
# mux_stream_nto1

Parametrised N-to-1 registered stream multiplexer. It generalises the lab 2-to-1 mux to N channels of WIDTH bits, with valid/ready flow control on every input and on the output. The channel is chosen by one of three modes: external select, fixed priority, or round-robin. The block is the shared selection stage ahead of any single-consumer datapath (UART TX, display driver) in later labs.

## Interface
- `WIDTH`, 8, data width per channel (>= 1)
- `N`, 4, number of input channels (>= 2)
- `MODE`, 2, selection policy: 0 = external `sel`, 1 = fixed priority, 2 = round-robin
- `SW`, `$clog2(N)`, select/channel-index width (derived, not overridden)

- `clk`  in  1  rising-edge clock
- `rst`  in  1  reset, asynchronous, active-high
- `in_data`  in  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- `in_valid`  in  N  channel i has a word
- `in_ready`  out  N  channel i word taken this cycle when `in_valid[i] && in_ready[i]`
- `sel`  in  SW  channel select, used only when MODE = 0
- `out_data`  out  WIDTH  registered output word
- `out_chan`  out  SW  source channel of `out_data`
- `out_valid`  out  1  output register holds a word
- `out_ready`  in  1  consumer accepts when `out_valid && out_ready`

## Operation
- One-entry output register; `load = !out_valid || out_ready`.
- Each cycle, a one-hot `grant[N-1:0]` is computed combinationally from `in_valid`, `sel`/pointer and MODE.
- `in_ready[i] = load && grant[i]`. At most one bit is set. All bits are 0 when no channel is eligible.
- On a handshake with channel g: `out_data <= in_data[g]`, `out_chan <= g`, `out_valid <= 1`.
- If `load` is high and no grant is given, `out_valid <= 0`. `out_data`/`out_chan` hold their last values.
- MODE 0: grant = `sel` only if `in_valid[sel]`.
  - If `sel >= N` (N not a power of two), no grant.
  - `sel` may change on any cycle; it is sampled only in the cycle it is used.
- MODE 1: lowest-index valid channel wins.
- MODE 2: round-robin.
  - Pointer `ptr` (SW bits) names the highest-priority channel.
  - Search order is `ptr, ptr+1, …, N-1, 0, …, ptr-1`.
  - After a handshake with g, `ptr <= (g == N-1) ? 0 : g+1`.
  - Wrap is explicit, so it is correct for N not a power of two.
  - `ptr` is unchanged when there is no handshake. A stalled output never advances the pointer.
  - `ptr` exists only in MODE 2. In other modes it is tied to 0.
- Inputs must hold `in_valid`/`in_data` until accepted. The block never drops a presented word.
- `in_ready` may depend on `in_valid` of any channel. `out_valid` never depends combinationally on `out_ready`.

## Timing
- Reset values: `out_valid = 0`, `out_data = 0`, `out_chan = 0`, `ptr = 0`. `in_ready` is 0 while `rst` is high.
- Latency: a word accepted on edge k appears on `out_data` with `out_valid = 1` after edge k.
- Throughput: 1 word/cycle while `out_ready` stays high.
- Full: `out_valid && !out_ready` gives `in_ready = 0` on all channels. The register and `ptr` are held.
- Simultaneous drain and fill: with `out_valid && out_ready` and a granted channel, the old word leaves and the new word loads on the same edge. There is no bubble.
- Reset mid-transfer: asynchronous assertion clears `out_valid` and `ptr` immediately. A held word is discarded. Inputs see `in_ready = 0` and must re-present.
- Reset release is synchronous to `clk` by the caller. The first grant is possible on the first edge after `rst` falls.

## Structure
- Package `mux_pkg` holds the MODE constants `MODE_SEL = 0`, `MODE_PRIO = 1`, `MODE_RR = 2`, plus the helper function for the next pointer with wrap.
- Sub-module `rr_arbiter` has parameter N and ports `clk`, `rst`, `req[N]`, `adv`, `grant[N]`. It owns `ptr` and is instantiated only when MODE = 2.
- The top level keeps the output register, the MODE 0/1 grant logic and the data mux.

## Test plan
- Reset: hold `rst` = 1 with all `in_valid` = 1. Expect `out_valid` = 0, `in_ready` = 0, `out_data` = 0. After release, expect the first word on the edge after the first grant.
- MODE 0 (N=4, W=8): `in_data` = {8'h44, 8'h33, 8'h22, 8'h11}, all valid, `sel` = 2. Expect `out_data` = 8'h33, `out_chan` = 2, `in_ready` = 4'b0100. With `sel` = 2 and `in_valid[2]` = 0, expect no handshake.
- MODE 1: `in_valid` = 4'b1010. Expect channel 1 granted. Then drop `in_valid[1]`; expect channel 3 granted.
- MODE 2: all channels valid, `out_ready` = 1 for 8 cycles. Expect `out_chan` sequence 0,1,2,3,0,1,2,3. With N=3, expect 0,1,2,0 (wrap check).
- Backpressure: `out_ready` = 0 for 5 cycles with all valid. Expect `in_ready` = 0, `out_data` stable, `ptr` unchanged. On release, expect back-to-back transfers and no lost or duplicated words (scoreboard per channel).
- Async reset mid-stream: assert `rst` between edges while `out_valid` = 1. Expect `out_valid` to fall without waiting for `clk`, and round-robin to restart at channel 0.
